// File: rtl/alu_seq.sv
// Registered, valid/ready handshaked ALU with status flags {V,C,N,Z} and illegal-opcode error.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 9 (otherwise opcode 9 is illegal).
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;

    state_t state, state_next;

    logic accept;
    logic start_mul;
    logic mul_done;

    logic [SHW-1:0]   sh_amt;
    logic [WIDTH:0]   sum_w, diff_w, shl_w, shr_w;
    logic [WIDTH-1:0] comb_res;
    logic             comb_c, comb_v, comb_err;

    assign accept = (state == IDLE) && in_valid;

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd9;

    logic [SHW-1:0]       cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mul_sum;
    logic [WIDTH-1:0]     mplier;

    assign start_mul = accept && (opcode == OP_MUL);
    assign mul_done  = (state == BUSY) && (cnt == {SHW{1'b1}});
    assign mul_sum   = acc + (mplier[0] ? mcand : '0);

    // One shift-add step per BUSY cycle; the last step feeds the result register directly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else if (start_mul) begin
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
        end else if (state == BUSY) begin
            cnt    <= cnt + 1'b1;
            mcand  <= mcand << 1;
            acc    <= mul_sum;
            mplier <= mplier >> 1;
        end
    end
`else
    assign start_mul = 1'b0;
    assign mul_done  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = start_mul ? BUSY : DONE;
                end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                if (mul_done) begin
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Wide intermediates expose carry/borrow and the last bit shifted out in bit WIDTH / bit 0.
    always_comb begin
        sh_amt   = b[SHW-1:0];
        sum_w    = {1'b0, a} + {1'b0, b};
        diff_w   = {1'b0, a} - {1'b0, b};
        shl_w    = {1'b0, a} << sh_amt;
        shr_w    = {a, 1'b0} >> sh_amt;
        comb_res = '0;
        comb_c   = 1'b0;
        comb_v   = 1'b0;
        comb_err = 1'b0;
        case (opcode)
            OP_ADD, OP_MOV: begin
                comb_res = sum_w[WIDTH-1:0];
                comb_c   = sum_w[WIDTH];
                comb_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                comb_res = diff_w[WIDTH-1:0];
                comb_c   = diff_w[WIDTH];
                comb_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: comb_res = a & b;
            OP_OR:  comb_res = a | b;
            OP_NOT: comb_res = ~a;
            OP_XOR: comb_res = a ^ b;
            OP_SHL: begin
                comb_res = shl_w[WIDTH-1:0];
                comb_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                comb_res = shr_w[WIDTH:1];
                comb_c   = shr_w[0];
            end
            default: comb_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result <= '0;
            flags  <= '0;
            err    <= 1'b0;
        end else if (accept && !start_mul) begin
            result <= comb_res;
            flags  <= comb_err ? 4'b0000
                               : {comb_v, comb_c, comb_res[WIDTH-1], (comb_res == '0)};
            err    <= comb_err;
`ifdef ALU_MUL_EN
        end else if (mul_done) begin
            result <= mul_sum[WIDTH-1:0];
            flags  <= {1'b0, (mul_sum[2*WIDTH-1:WIDTH] != '0), mul_sum[WIDTH-1],
                       (mul_sum[WIDTH-1:0] == '0)};
            err    <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH=16); expectations follow ALU_MUL_EN when it is defined.
module tb_alu_seq;

    localparam int WIDTH = 16;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;
        logic        er;
        int          lat;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = 4'd0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        err;

    int checks = 0;
    int passes = 0;
    vec_t vecs[$];

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one request, scramble inputs after the accept edge, and count edges until out_valid.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                                 output int lat);
        @(negedge clk);
        opcode   = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = 4'd3;
        a        = ~av;
        b        = ~bv;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic runVector(input vec_t v);
        int lat;
        applyStimulus(v.op, v.a, v.b, lat);
        checkOutput({v.name, " latency"}, lat, v.lat);
        checkOutput({v.name, " result"}, {16'h0, result}, {16'h0, v.res});
        checkOutput({v.name, " flags"}, {28'h0, flags}, {28'h0, v.flg});
        checkOutput({v.name, " err"}, {31'h0, err}, {31'h0, v.er});
        // Stalled consumer: outputs must hold and a competing request must be refused.
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            opcode   = 4'd0;
            a        = 16'h0101;
            b        = 16'h0101;
            @(posedge clk);
            #1;
            checkOutput({v.name, " hold result"}, {16'h0, result}, {16'h0, v.res});
            checkOutput({v.name, " hold flags"}, {28'h0, flags}, {28'h0, v.flg});
            checkOutput({v.name, " hold out_valid"}, {31'h0, out_valid}, 32'h1);
            checkOutput({v.name, " hold in_ready"}, {31'h0, in_ready}, 32'h0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        opcode    = 4'd0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput({v.name, " drain out_valid"}, {31'h0, out_valid}, 32'h0);
        checkOutput({v.name, " drain in_ready"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        int lat;
        vec_t v;

        vecs.push_back('{"add_ovf",  4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1010, 1'b0, 1, 0});
        vecs.push_back('{"sub_brw",  4'd1,  16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1'b0, 1, 5});
        vecs.push_back('{"shl1",     4'd7,  16'h8001, 16'h0001, 16'h0002, 4'b0100, 1'b0, 1, 0});
        vecs.push_back('{"shr0",     4'd8,  16'h0001, 16'h0000, 16'h0001, 4'b0000, 1'b0, 1, 0});
        vecs.push_back('{"and",      4'd2,  16'hF0F0, 16'hFF00, 16'hF000, 4'b0010, 1'b0, 1, 0});
        vecs.push_back('{"or",       4'd3,  16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 1'b0, 1, 0});
        vecs.push_back('{"not",      4'd4,  16'h00FF, 16'h1234, 16'hFF00, 4'b0010, 1'b0, 1, 0});
        vecs.push_back('{"mov",      4'd5,  16'h1234, 16'h0000, 16'h1234, 4'b0000, 1'b0, 1, 0});
        vecs.push_back('{"xor_z",    4'd6,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001, 1'b0, 1, 0});
        vecs.push_back('{"add_cz",   4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0101, 1'b0, 1, 0});
        vecs.push_back('{"sub_ovf",  4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b1000, 1'b0, 1, 0});
        vecs.push_back('{"shr15",    4'd8,  16'hC000, 16'h000F, 16'h0001, 4'b0100, 1'b0, 1, 0});
        vecs.push_back('{"shl15",    4'd7,  16'h0003, 16'h001F, 16'h8000, 4'b0110, 1'b0, 1, 0});
        vecs.push_back('{"ill12",    4'd12, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 1'b1, 1, 0});
        vecs.push_back('{"add_clr",  4'd0,  16'h0001, 16'h0001, 16'h0002, 4'b0000, 1'b0, 1, 0});
        vecs.push_back('{"ill15",    4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000, 1'b1, 1, 0});
`ifdef ALU_MUL_EN
        vecs.push_back('{"mul_hi",   4'd9,  16'h0100, 16'h0100, 16'h0000, 4'b0101, 1'b0, 17, 0});
        vecs.push_back('{"mul_lo",   4'd9,  16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b0, 17, 2});
        vecs.push_back('{"mul_neg",  4'd9,  16'h00FF, 16'h0101, 16'hFFFF, 4'b0010, 1'b0, 17, 0});
`else
        vecs.push_back('{"mul_ill",  4'd9,  16'h0100, 16'h0100, 16'h0000, 4'b0000, 1'b1, 1, 0});
        vecs.push_back('{"mul_ill2", 4'd9,  16'h0003, 16'h0005, 16'h0000, 4'b0000, 1'b1, 1, 0});
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset result", {16'h0, result}, 32'h0);
        checkOutput("reset flags", {28'h0, flags}, 32'h0);
        checkOutput("reset err", {31'h0, err}, 32'h0);
        checkOutput("reset out_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-reset in_ready", {31'h0, in_ready}, 32'h1);

        foreach (vecs[i]) begin
            runVector(vecs[i]);
        end

        // Abort a multiply mid-flight: reset must drop the pending result entirely.
        v = '{"pre_abort", 4'd0, 16'h0100, 16'h0023, 16'h0123, 4'b0000, 1'b0, 1, 0};
        runVector(v);
        @(negedge clk);
        opcode   = 4'd9;
        a        = 16'h0100;
        b        = 16'h0100;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("abort in_ready", {31'h0, in_ready}, 32'h1);
`ifdef ALU_MUL_EN
        checkOutput("abort result", {16'h0, result}, 32'h0);
`else
        checkOutput("abort err", {31'h0, err}, 32'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort idle out_valid", {31'h0, out_valid}, 32'h0);
        v = '{"and_after", 4'd2, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0010, 1'b0, 1, 0};
        runVector(v);

        // Back-to-back ops with in_valid held high: the second must wait for the drain.
        @(negedge clk);
        opcode   = 4'd0;
        a        = 16'h0010;
        b        = 16'h0020;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("b2b first result", {16'h0, result}, 32'h0030);
        checkOutput("b2b first in_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        opcode = 4'd6;
        a      = 16'h00FF;
        b      = 16'h0F0F;
        @(posedge clk);
        #1;
        checkOutput("b2b idle result", {16'h0, result}, 32'h0030);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        checkOutput("b2b second result", {16'h0, result}, 32'h0FF0);
        checkOutput("b2b second out_valid", {31'h0, out_valid}, 32'h1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(4'd1, 16'h0005, 16'h0005, lat);
        checkOutput("sub_zero latency", lat, 1);
        checkOutput("sub_zero flags", {28'h0, flags}, 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, handshaked, parametrised ALU; next-generation replacement for the combinational `alu` in the CPU datapath. Accepts one operation per transaction on a valid/ready input port, returns a registered result plus status flags on a valid/ready output port. Adds XOR, shifts, flags, an illegal-opcode error and an optional iterative multiplier.

## Interface
- `WIDTH`, 16: operand/result width in bits (≥4, power of two).
- `SHW`, $clog2(WIDTH): shift-amount bits taken from `b[SHW-1:0]`.
- `clk` in 1: clock, all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: operation request valid.
- `in_ready` out 1: block can accept a request.
- `opcode` in 4: operation select (encoding below).
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `out_valid` out 1: result/flags valid.
- `out_ready` in 1: consumer accepts result.
- `result` out WIDTH: operation result.
- `flags` out 4: {V, C, N, Z}.
- `err` out 1: illegal/unsupported opcode in this result.

## Operation
- Opcodes: 0 ADD a+b; 1 SUB a−b; 2 AND; 3 OR; 4 NOT ~a; 5 MOV a+b (b=0 for plain move); 6 XOR; 7 SHL a<<b[SHW-1:0]; 8 SHR logical a>>b[SHW-1:0]; 9 MUL low WIDTH bits of a×b (unsigned); 10–15 illegal.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_ready`=1. On `in_valid`: opcode 9 (multiplier compiled in) → BUSY, latch a, b, clear accumulator; any other opcode → compute, register result/flags/err, → DONE.
  - BUSY: one shift-add step per cycle, counter 0..WIDTH−1; after step WIDTH−1 register product and flags, → DONE.
  - DONE: `out_valid`=1, outputs held stable; on `out_ready` → IDLE.
- `in_ready` high only in IDLE; `out_valid` high only in DONE. No new request accepted in DONE, even with `out_ready` high.
- Flags: Z = (result==0); N = result[WIDTH−1].
  - C: ADD/MOV carry-out; SUB borrow (a<b unsigned); SHL last bit shifted out of MSB; SHR last bit shifted out of LSB; shift amount 0 → C=0; MUL high-half nonzero; else 0.
  - V: ADD/MOV signed overflow (operands same sign, result differs); SUB signed overflow (operands differ in sign, result sign ≠ a sign); else 0.
- Illegal opcode: result=0, flags=0, `err`=1, still completes via DONE in one cycle.
- Arithmetic modulo 2^WIDTH; internal sums WIDTH+1 bits, product 2·WIDTH bits.

## Timing
- Reset (`reset_n`=0 at edge): state IDLE, counter 0, `result`=0, `flags`=0, `err`=0, `out_valid`=0; `in_ready`=1 from first cycle after reset released. Reset in BUSY or DONE aborts and drops the pending result.
- Single-cycle ops: accepted at edge N, `out_valid`=1 from edge N+1.
- MUL: accepted at edge N, `out_valid`=1 from edge N+WIDTH+1.
- Best-case throughput: one op per 2 cycles (IDLE→DONE→IDLE).
- Inputs `opcode`, `a`, `b` sampled only at accept edge; later changes ignored.
- `result`/`flags`/`err` are registers; no combinational path from inputs to outputs; `in_ready`, `out_valid` decoded from state only.

## Configuration
- `ALU_MUL_EN` defined: opcode 9 runs iterative multiplier (BUSY state, counter, accumulator present).
- Not defined: BUSY/multiplier logic removed; opcode 9 treated as illegal (result 0, flags 0, `err`=1, single-cycle latency).

## Test plan
- Reset then ADD a=0x7FFF b=0x0001 (WIDTH=16) → after 1 cycle `out_valid`=1, result=0x8000, V=1 N=1 C=0 Z=0.
- SUB a=0x0003 b=0x0005 → result=0xFFFE, C=1 (borrow), N=1; hold `out_ready`=0 for 5 cycles → outputs stable, `in_ready`=0 throughout.
- SHL a=0x8001 b=1 → result=0x0002, C=1; SHR a=0x0001 b=0 → result=0x0001, C=0.
- With `ALU_MUL_EN`: MUL a=0x0100 b=0x0100 → `out_valid` exactly 17 cycles after accept, result=0x0000, Z=1, C=1; without macro → result 0, `err`=1 after 1 cycle.
- Opcode 12 → result=0, flags=0, `err`=1; next ADD clears `err`.
- Start MUL, assert `reset_n`=0 at BUSY cycle 5 → next cycle IDLE, `out_valid`=0, result=0; new AND a=0xF0F0 b=0xFF00 → 0xF000.
